// File: rtl/fsm9_acc_pkg.sv
// Shared types for the nine-state sequenced accumulator.
// State codes 9..15 are illegal and recover to S0.
package fsm9_acc_pkg;

    localparam int STATE_W    = 4;
    localparam int NUM_STATES = 9;

    typedef enum logic [STATE_W-1:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_e;

endpackage

// File: rtl/fsm9_acc_if.sv
// Per-state advance conditions, per-state constants, operand and result bus.
// The master drives the controls; the slave (the accumulator) returns y.
interface fsm9_acc_if #(
    parameter int WIDTH = 4
);
    logic             i0, i1, i2, i3, i4, i5, i6, i7, i8;
    logic [WIDTH-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] y;

    modport master (
        output i0, i1, i2, i3, i4, i5, i6, i7, i8,
        output c0, c1, c2, c3, c4, c5, c6, c7, c8,
        output en, a,
        input  y
    );

    modport slave (
        input  i0, i1, i2, i3, i4, i5, i6, i7, i8,
        input  c0, c1, c2, c3, c4, c5, c6, c7, c8,
        input  en, a,
        output y
    );
endinterface

// File: rtl/fsm9_acc_next.sv
// Combinational next-state and constant-select for the nine-state ring.
// Illegal codes select a zero constant and return to S0.
module fsm9_next
    import fsm9_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  state_e                           i_state,
    input  logic [NUM_STATES-1:0]            i_adv,
    input  logic [NUM_STATES-1:0][WIDTH-1:0] i_c,
    output state_e                           o_next,
    output logic [WIDTH-1:0]                 o_csel
);

    always_comb begin
        o_next = S0;
        o_csel = '0;
        case (i_state)
            S0: begin o_csel = i_c[0]; o_next = i_adv[0] ? S1 : S0; end
            S1: begin o_csel = i_c[1]; o_next = i_adv[1] ? S2 : S1; end
            S2: begin o_csel = i_c[2]; o_next = i_adv[2] ? S3 : S2; end
            S3: begin o_csel = i_c[3]; o_next = i_adv[3] ? S4 : S3; end
            S4: begin o_csel = i_c[4]; o_next = i_adv[4] ? S5 : S4; end
            S5: begin o_csel = i_c[5]; o_next = i_adv[5] ? S6 : S5; end
            S6: begin o_csel = i_c[6]; o_next = i_adv[6] ? S7 : S6; end
            S7: begin o_csel = i_c[7]; o_next = i_adv[7] ? S8 : S7; end
            S8: begin o_csel = i_c[8]; o_next = i_adv[8] ? S0 : S8; end
            default: begin
                o_next = S0;
                o_csel = '0;
            end
        endcase
    end

endmodule

// File: rtl/fsm9_acc.sv
// Nine-state controller with a registered y <= a + c[state] when enabled.
// y is purely registered, so feeding y back into a is a legal loop.
module fsm9_acc
    import fsm9_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    fsm9_acc_if.slave  bus
);

    state_e                           r_state;
    logic [WIDTH-1:0]                 r_y;
    state_e                           w_next;
    logic [WIDTH-1:0]                 w_csel;
    logic [NUM_STATES-1:0]            w_adv;
    logic [NUM_STATES-1:0][WIDTH-1:0] w_c;

    assign w_adv = {bus.i8, bus.i7, bus.i6, bus.i5, bus.i4,
                    bus.i3, bus.i2, bus.i1, bus.i0};
    assign w_c   = {bus.c8, bus.c7, bus.c6, bus.c5, bus.c4,
                    bus.c3, bus.c2, bus.c1, bus.c0};

    fsm9_next #(.WIDTH(WIDTH)) u_next (
        .i_state (r_state),
        .i_adv   (w_adv),
        .i_c     (w_c),
        .o_next  (w_next),
        .o_csel  (w_csel)
    );

    // State advance ignores en; the sum wraps modulo 2^WIDTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            if (bus.en)
                r_y <= bus.a + w_csel;
        end
    end

    assign bus.y = r_y;

endmodule

// File: tb/tb_fsm9_acc.sv
// Directed vector table plus hand sequences for reset, wrap and illegal state.
module tb_fsm9_acc;
    import fsm9_acc_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fsm9_acc_if #(.WIDTH(4)) bus ();

    fsm9_acc #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [8:0] adv;
        logic       en;
        logic       fb;
        logic [3:0] a;
        logic       rst;
        logic [3:0] exp_y;
        logic [3:0] exp_s;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic [8:0] adv, input logic en, input logic fb,
                       input logic [3:0] a, input logic rst,
                       input logic [3:0] ey, input logic [3:0] es);
        vec_t v;
        v = '{adv: adv, en: en, fb: fb, a: a, rst: rst, exp_y: ey, exp_s: es};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_adv(input logic [8:0] adv);
        {bus.i8, bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = adv;
    endtask

    task automatic set_consts_k();
        bus.c0 = 4'd0; bus.c1 = 4'd1; bus.c2 = 4'd2; bus.c3 = 4'd3; bus.c4 = 4'd4;
        bus.c5 = 4'd5; bus.c6 = 4'd6; bus.c7 = 4'd7; bus.c8 = 4'd8;
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic step(input logic [8:0] adv, input logic en, input logic fb,
                        input logic [3:0] a, input logic rst);
        set_adv(adv);
        bus.en = en;
        bus.a  = fb ? bus.y : a;
        reset  = rst;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] cur_state();
        return 4'(dut.r_state);
    endfunction

    initial begin
        reset = 1'b1;
        set_adv(9'h000);
        set_consts_k();
        bus.en = 1'b0;
        bus.a  = 4'd0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("reset_y", bus.y, 4'd0);
        check("reset_state", cur_state(), 4'd0);

        // Feedback run with c_k = k: 0,1,3,6,10,15,5,12,4 then 4,5.
        add(9'h1FF, 1, 1, 0, 0,  0, 1);
        add(9'h1FF, 1, 1, 0, 0,  1, 2);
        add(9'h1FF, 1, 1, 0, 0,  3, 3);
        add(9'h1FF, 1, 1, 0, 0,  6, 4);
        add(9'h1FF, 1, 1, 0, 0, 10, 5);
        add(9'h1FF, 1, 1, 0, 0, 15, 6);
        add(9'h1FF, 1, 1, 0, 0,  5, 7);
        add(9'h1FF, 1, 1, 0, 0, 12, 8);
        add(9'h1FF, 1, 1, 0, 0,  4, 0);
        add(9'h1FF, 1, 1, 0, 0,  4, 1);
        add(9'h1FF, 1, 1, 0, 0,  5, 2);
        // i3 low: hold in S3, +3 per cycle, then release.
        add(9'h1F7, 1, 1, 0, 0,  7, 3);
        add(9'h1F7, 1, 1, 0, 0, 10, 3);
        add(9'h1F7, 1, 1, 0, 0, 13, 3);
        add(9'h1FF, 1, 1, 0, 0,  0, 4);
        // en low: y holds while state advances; re-enable uses S6 constant.
        add(9'h1FF, 0, 1, 0, 0,  0, 5);
        add(9'h1FF, 0, 1, 0, 0,  0, 6);
        add(9'h1FF, 1, 1, 0, 0,  6, 7);
        add(9'h1FF, 1, 1, 0, 0, 13, 8);
        add(9'h000, 1, 1, 0, 0,  5, 8);
        add(9'h1FF, 1, 1, 0, 0, 13, 0);
        // Open-loop operand, wrap in S1, then reset overriding en.
        add(9'h1FF, 1, 0, 9, 0,  9, 1);
        add(9'h1FF, 1, 0, 15, 0, 0, 2);
        add(9'h1FF, 1, 0, 7, 1,  0, 0);

        reset = 1'b0;
        foreach (vecs[i]) begin
            step(vecs[i].adv, vecs[i].en, vecs[i].fb, vecs[i].a, vecs[i].rst);
            check($sformatf("vec%0d_y", i), bus.y, vecs[i].exp_y);
            check($sformatf("vec%0d_state", i), cur_state(), vecs[i].exp_s);
        end

        // Reset asserted in S5, then first edge after release uses c0.
        step(9'h1FF, 1, 0, 0, 1);
        bus.c0 = 4'd2;
        for (int k = 0; k < 5; k++) step(9'h1FF, 1, 0, 4'd1, 0);
        check("pre_reset_state", cur_state(), 4'd5);
        step(9'h1FF, 1, 0, 4'd3, 1);
        check("mid_reset_y", bus.y, 4'd0);
        check("mid_reset_state", cur_state(), 4'd0);
        step(9'h1FF, 1, 0, 4'd3, 0);
        check("post_reset_y", bus.y, 4'd5);
        check("post_reset_state", cur_state(), 4'd1);

        // Wrap: a=15 + c0=15 -> 14.
        step(9'h1FF, 0, 0, 0, 1);
        bus.c0 = 4'd15;
        step(9'h1FF, 1, 0, 4'd15, 0);
        check("wrap_y", bus.y, 4'd14);
        check("wrap_state", cur_state(), 4'd1);

        // Illegal state 12: constant is zero, machine recovers to S0.
        @(negedge clock);
        force dut.r_state = state_e'(4'd12);
        set_adv(9'h1FF);
        bus.en = 1'b1;
        bus.a  = 4'd6;
        @(posedge clock); #1;
        check("illegal_y", bus.y, 4'd6);
        release dut.r_state;
        step(9'h000, 0, 0, 4'd9, 0);
        check("illegal_recover_state", cur_state(), 4'd0);
        check("illegal_hold_y", bus.y, 4'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
